// File: rtl/smith_waterman_pkg.sv
// Shared types for the Smith-Waterman AFU: CCI-P channel-1 subset, DSM status line layout, writer FSM states.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package smith_waterman_pkg;

  localparam int CCIP_CL_W = 512;
  localparam logic [15:0] DSM_MDATA_DEFAULT = 16'hD5D5;
  localparam logic [31:0] DSM_DONE_MARKER = 32'h0000_0001;

  // Host address in cache-line units
  typedef logic [41:0] t_hc_address;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_cl_len;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_cl_len cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_hc_address  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr   hdr;
    logic [CCIP_CL_W-1:0] data;
    logic                 valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef enum logic [1:0] {
    DSM_IDLE     = 2'd0,
    DSM_RUN      = 2'd1,
    DSM_WRITE    = 2'd2,
    DSM_WAIT_RSP = 2'd3
  } t_dsm_state;

  // Status line as seen by host software, LSB first: marker, score, cycles, seq
  typedef struct packed {
    logic [351:0] rsvd;
    logic [31:0]  seq;
    logic [63:0]  cycles;
    logic [31:0]  score;
    logic [31:0]  marker;
  } t_dsm_line;

  function automatic t_dsm_line make_dsm_line(input logic [31:0] score,
                                              input logic [63:0] cycles,
                                              input logic [31:0] seq);
    t_dsm_line line;
    line        = '0;
    line.marker = DSM_DONE_MARKER;
    line.score  = score;
    line.cycles = cycles;
    line.seq    = seq;
    return line;
  endfunction

endpackage

// File: rtl/smith_waterman_cycle_counter.sv
// 64-bit free-running cycle counter with synchronous clear and saturation at all-ones.
// Latency: count reflects enable one cycle after it is sampled; clear wins over enable.
// Backpressure: none; never wraps, sticks at all-ones.
module smith_waterman_cycle_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  // Count enabled cycles, holding at the ceiling instead of wrapping
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/smith_waterman_dsm_writer.sv
// Job timer and completion reporter: writes one status line to hc_dsm_base on c1 and waits for its response.
// Latency: done in cycle N -> c1Tx.valid in N+1 (almFull low); busy/complete update the cycle after the response.
// Backpressure: c1TxAlmFull high holds the request in WRITE with valid low; issued once almFull drops.
module smith_waterman_dsm_writer
  import smith_waterman_pkg::*;
#(
  parameter logic [15:0] DSM_MDATA = DSM_MDATA_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  t_hc_address    hc_dsm_base,
  input  logic           start,
  input  logic           done,
  input  logic [31:0]    score,
  output t_if_ccip_c1_Tx c1Tx,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c1_Rx c1Rx,
  output logic           busy,
  output logic           complete,
  output logic           err_nobase,
  output logic           err_overrun
);

  t_dsm_state         r_state;
  t_dsm_state         w_state_next;
  logic [31:0]        r_seq;
  logic               r_complete;
  logic               r_err_nobase;
  logic               r_err_overrun;
  logic               r_tx_valid;
  t_ccip_c1_ReqMemHdr r_tx_hdr;
  t_dsm_line          r_tx_dat;
  t_ccip_c1_ReqMemHdr w_tx_hdr;
  logic [63:0]        w_cycles;
  logic               w_base_zero;
  logic               w_accept_start;
  logic               w_done_run;
  logic               w_send;
  logic               w_rsp_match;

  assign w_base_zero = (hc_dsm_base == '0);

  smith_waterman_cycle_counter u_cycle_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_accept_start),
    .i_en    (r_state == DSM_RUN),
    .o_count (w_cycles)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DSM_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle strobes; a request is launched straight from the done cycle when possible
  always_comb begin
    w_state_next   = r_state;
    w_accept_start = 1'b0;
    w_done_run     = 1'b0;
    w_send         = 1'b0;
    w_rsp_match    = 1'b0;
    unique case (r_state)
      DSM_IDLE: begin
        if (start) begin
          w_accept_start = 1'b1;
          w_state_next   = DSM_RUN;
        end
      end
      DSM_RUN: begin
        if (done) begin
          w_done_run   = 1'b1;
          w_send       = !w_base_zero && !c1TxAlmFull;
          w_state_next = w_base_zero ? DSM_IDLE : DSM_WRITE;
        end
      end
      DSM_WRITE: begin
        // r_tx_valid high means the single request is on the bus this cycle
        if (r_tx_valid) begin
          w_state_next = DSM_WAIT_RSP;
        end else begin
          w_send = !c1TxAlmFull;
        end
      end
      DSM_WAIT_RSP: begin
        if (c1Rx.rspValid && (c1Rx.hdr.resp_type == eRSP_WRLINE) &&
            (c1Rx.hdr.mdata == DSM_MDATA)) begin
          w_rsp_match  = 1'b1;
          w_state_next = DSM_IDLE;
        end
      end
      default: w_state_next = DSM_IDLE;
    endcase
  end

  // Fixed write-line header for the status line
  always_comb begin
    w_tx_hdr          = '0;
    w_tx_hdr.vc_sel   = eVC_VA;
    w_tx_hdr.sop      = 1'b1;
    w_tx_hdr.cl_len   = eCL_LEN_1;
    w_tx_hdr.req_type = eREQ_WRLINE_I;
    w_tx_hdr.address  = hc_dsm_base;
    w_tx_hdr.mdata    = DSM_MDATA;
  end

  // c1 request register: payload captured at done, valid pulses exactly once per job
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_valid <= 1'b0;
      r_tx_hdr   <= '0;
      r_tx_dat   <= '0;
    end else begin
      r_tx_valid <= w_send;
      if (w_done_run && !w_base_zero) begin
        r_tx_hdr <= w_tx_hdr;
        r_tx_dat <= make_dsm_line(score, w_cycles, r_seq);
      end
    end
  end

  // Job sequence number and sticky status; later statements win, so overrun set beats start clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq         <= '0;
      r_complete    <= 1'b0;
      r_err_nobase  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_accept_start) begin
        r_seq         <= r_seq + 32'd1;
        r_complete    <= 1'b0;
        r_err_nobase  <= 1'b0;
        r_err_overrun <= 1'b0;
      end
      if (w_done_run && w_base_zero) begin
        r_err_nobase <= 1'b1;
        r_complete   <= 1'b1;
      end
      if (w_rsp_match) begin
        r_complete <= 1'b1;
      end
      if (done && (r_state != DSM_RUN)) begin
        r_err_overrun <= 1'b1;
      end
    end
  end

  assign c1Tx        = '{hdr: r_tx_hdr, data: r_tx_dat, valid: r_tx_valid};
  assign busy        = (r_state != DSM_IDLE);
  assign complete    = r_complete;
  assign err_nobase  = r_err_nobase;
  assign err_overrun = r_err_overrun;

endmodule

// File: doc/smith_waterman_dsm_writer.md
# smith_waterman_dsm_writer

Completion reporter for the Smith-Waterman AFU; the write-side counterpart to the MMIO CSR block. The host programs `hc_dsm_base` and kicks the job through CSRs; this block times the job and reports the result by pushing one 64-byte status line to `hc_dsm_base` over CCI-P channel 1. It then waits for the write response before declaring the job complete. It sits between the compute core and the c1 port of the MPF interface.

## Interface
Parameters:
- `DSM_MDATA`, 16'hD5D5: mdata tag stamped on the status write; used to match its response.

Ports:
- `clk`  in  1: AFU clock.
- `reset`  in  1: synchronous, active-high.
- `hc_dsm_base`  in  t_hc_address: status-line address (cache-line units), stable while busy.
- `start`  in  1: one-cycle job-start pulse from control decode.
- `done`  in  1: one-cycle compute-finished pulse.
- `score`  in  32: best alignment score, valid with `done`.
- `c1Tx`  out  t_if_ccip_c1_Tx: write request.
- `c1TxAlmFull`  in  1: c1 backpressure.
- `c1Rx`  in  t_if_ccip_c1_Rx: write responses.
- `busy`  out  1: high from accepted `start` until the response is received.
- `complete`  out  1: sticky, set on response, cleared by next accepted `start`.
- `err_nobase`  out  1: sticky; `done` arrived with `hc_dsm_base == 0`.
- `err_overrun`  out  1: sticky; `done` arrived outside RUN.

## Operation
- States: IDLE, RUN, WRITE, WAIT_RSP.
- IDLE: `start` leads to RUN. On entry to RUN, clear `complete`, `err_nobase`, `err_overrun` and the cycle counter; increment the 32-bit job sequence number (wraps).
- RUN: the cycle counter (64 b, saturating at all-ones) increments every cycle. On `done`, latch `score` and the counter value.
  - If `hc_dsm_base == 0`: set `err_nobase` and `complete`, go to IDLE, issue no write.
  - Otherwise go to WRITE.
- WRITE: while `c1TxAlmFull` is low, drive `c1Tx.valid` for exactly one cycle with:
  - `req_type` eREQ_WRLINE_I, `vc_sel` eVC_VA, `cl_len` eCL_LEN_1, `sop` 1;
  - `address` = `hc_dsm_base`, `mdata` = `DSM_MDATA`.
  - Then go to WAIT_RSP. If almFull is high, hold in WRITE with valid low.
- Status line layout:
  - [31:0] = 32'h0000_0001 (done marker)
  - [63:32] = score
  - [127:64] = cycle count
  - [159:128] = sequence number
  - remainder zero.
- WAIT_RSP: on `c1Rx.rspValid` with `resp_type` eRSP_WRLINE and `mdata == DSM_MDATA`, set `complete` and go to IDLE. Responses with other mdata are ignored.
- `start` outside IDLE is ignored. `done` outside RUN sets `err_overrun` and is otherwise ignored.
- `done` and `start` in the same IDLE cycle: `start` wins and `done` flags overrun.

## Timing
- Reset values: state IDLE, `c1Tx.valid` 0, `busy` 0, `complete` 0, both errors 0, counter 0, sequence number 0.
- `c1Tx` is registered. With almFull low, `done` in cycle N produces valid in cycle N+1.
- `busy` rises the cycle after `start` and falls the cycle after the matching response.
- `complete` rises in that same cycle.
- Cycle count = number of RUN cycles before the `done` cycle. A `done` on the first RUN cycle reports 0.
- Reset mid-operation forces IDLE immediately. A late response arriving in IDLE is ignored.

## Structure
- Add to smith_waterman_pkg: `t_dsm_state` enum, `t_dsm_line` packed struct for the line layout, and the `DSM_MDATA` default constant.
- Single module. The sub-module `smith_waterman_cycle_counter` (64-bit saturating, sync clear) is natural and reused for perf counters.

## Test plan
- base=0x1000, start, done after 100 cycles with score=0x2A, almFull low: one write to 0x1000, data[63:32]=0x2A, [127:64]=100, [159:128]=1. Response then sets complete; busy spans start+1..rsp+1.
- almFull held high 20 cycles after done: valid stays low, then exactly one request is issued when almFull drops.
- base=0, start, done: no c1Tx valid, err_nobase=1, complete=1.
- done during WAIT_RSP, and start during RUN: err_overrun=1, state and sequence unaffected, single write.
- Response with mdata 0x1234 in WAIT_RSP: ignored, busy stays high. Matching response then completes.
- Reset asserted in WRITE with almFull high: valid never asserts, all outputs at reset values; next job reports sequence 1.
